// File: rtl/ip_checksum_gen_if.sv
// AXI4-Stream bundle used on both sides of the IPv4 checksum generator.
// The master drives the beat, the slave drives tready.
interface ip_checksum_gen_if #(
   parameter int DATA_WIDTH  = 256,
   parameter int TUSER_WIDTH = 128
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ip_checksum_gen.sv
// Transmit-side IPv4 header checksum generator: recomputes the header checksum of
// eligible option-free IPv4 frames and writes it into beat 0; all other traffic passes through.
module ip_checksum_gen #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   ip_checksum_gen_if.slave      s_axis,
   ip_checksum_gen_if.master     m_axis,
   output logic                  csum_inserted
);
   localparam int DW     = C_S_AXIS_DATA_WIDTH;
   localparam int UW     = C_S_AXIS_TUSER_WIDTH;
   localparam int KEEP_W = DW / 8;

   function automatic logic [15:0] word_at(input logic [DW-1:0] d, input int n);
      return {d[8*n +: 8], d[8*(n+1) +: 8]};
   endfunction

   logic              h_valid_q, h_valid_d;
   logic [DW-1:0]     h_data_q, h_data_d;
   logic [KEEP_W-1:0] h_keep_q, h_keep_d;
   logic [UW-1:0]     h_user_q, h_user_d;
   logic              h_last_q, h_last_d;
   logic              h_first_q, h_first_d;
   logic              h_elig_q, h_elig_d;

   logic              o_valid_q, o_valid_d;
   logic [DW-1:0]     o_data_q, o_data_d;
   logic [KEEP_W-1:0] o_keep_q, o_keep_d;
   logic [UW-1:0]     o_user_q, o_user_d;
   logic              o_last_q, o_last_d;
   logic              o_ins_q, o_ins_d;

   logic              first_q, first_d;
   logic [19:0]       psum_q, psum_d;

   logic              hold_ok, o_space, h_move, s_ready, s_accept, elig_new;
   logic [19:0]       psum_new, sum_full;
   logic [16:0]       fold1;
   logic [15:0]       fold2, csum;

   // Partial sum of the eight header words carried by beat 0 (checksum word skipped).
   always_comb begin
      psum_new = '0;
      for (int i = 14; i < 32; i += 2) begin
         if (i != 24) psum_new = psum_new + {4'd0, word_at(s_axis.tdata, i)};
      end
   end

   always_comb begin
      sum_full = psum_q + {4'd0, word_at(s_axis.tdata, 0)};
      fold1    = {1'b0, sum_full[15:0]} + {13'd0, sum_full[19:16]};
      fold2    = fold1[15:0] + {15'd0, fold1[16]};
      csum     = ~fold2;

      elig_new = (s_axis.tdata[8*12 +: 8] == 8'h08) && (s_axis.tdata[8*13 +: 8] == 8'h00) &&
                 (s_axis.tdata[8*14 +: 8] == 8'h45) && (&s_axis.tkeep) && !s_axis.tlast;

      // A multi-beat beat 0 may only leave H on the edge that accepts beat 1,
      // since the checksum needs beat 1's first word.
      hold_ok  = !h_first_q || h_last_q || s_axis.tvalid;
      o_space  = !o_valid_q || m_axis.tready;
      h_move   = h_valid_q && o_space && hold_ok;
      s_ready  = !h_valid_q || h_move;
      s_accept = s_axis.tvalid && s_ready;
   end

   always_comb begin
      h_valid_d = h_valid_q;
      h_data_d  = h_data_q;
      h_keep_d  = h_keep_q;
      h_user_d  = h_user_q;
      h_last_d  = h_last_q;
      h_first_d = h_first_q;
      h_elig_d  = h_elig_q;
      first_d   = first_q;
      psum_d    = psum_q;

      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_keep_d  = o_keep_q;
      o_user_d  = o_user_q;
      o_last_d  = o_last_q;
      o_ins_d   = o_ins_q;

      if (h_move) h_valid_d = 1'b0;

      if (s_accept) begin
         h_valid_d = 1'b1;
         h_data_d  = s_axis.tdata;
         h_keep_d  = s_axis.tkeep;
         h_user_d  = s_axis.tuser;
         h_last_d  = s_axis.tlast;
         h_first_d = first_q;
         h_elig_d  = first_q && elig_new;
         first_d   = s_axis.tlast;
         if (first_q) psum_d = psum_new;
      end

      if (h_move) begin
         o_valid_d = 1'b1;
         o_data_d  = h_data_q;
         o_keep_d  = h_keep_q;
         o_user_d  = h_user_q;
         o_last_d  = h_last_q;
         o_ins_d   = h_first_q && h_elig_q;
         if (h_first_q && h_elig_q) begin
            o_data_d[8*24 +: 8] = csum[15:8];
            o_data_d[8*25 +: 8] = csum[7:0];
         end
      end else if (m_axis.tready) begin
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_valid_q <= 1'b0;
         h_data_q  <= '0;
         h_keep_q  <= '0;
         h_user_q  <= '0;
         h_last_q  <= 1'b0;
         h_first_q <= 1'b0;
         h_elig_q  <= 1'b0;
         first_q   <= 1'b1;
         psum_q    <= '0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_keep_q  <= '0;
         o_user_q  <= '0;
         o_last_q  <= 1'b0;
         o_ins_q   <= 1'b0;
      end else begin
         h_valid_q <= h_valid_d;
         h_data_q  <= h_data_d;
         h_keep_q  <= h_keep_d;
         h_user_q  <= h_user_d;
         h_last_q  <= h_last_d;
         h_first_q <= h_first_d;
         h_elig_q  <= h_elig_d;
         first_q   <= first_d;
         psum_q    <= psum_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_keep_q  <= o_keep_d;
         o_user_q  <= o_user_d;
         o_last_q  <= o_last_d;
         o_ins_q   <= o_ins_d;
      end
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = o_valid_q;
   assign m_axis.tdata  = o_data_q;
   assign m_axis.tkeep  = o_keep_q;
   assign m_axis.tuser  = o_user_q;
   assign m_axis.tlast  = o_last_q;
   assign csum_inserted = o_valid_q && o_ins_q && m_axis.tready;
endmodule

// File: doc/ip_checksum_gen.md
# ip_checksum_gen

Transmit-side IPv4 header checksum generator for the 256-bit router datapath. Sits on the output AXI4-Stream path after header rewriting (TTL decrement, MAC swap) and before the output queues. For every eligible IPv4 packet it recomputes the full header checksum from scratch and writes it into the frame, complementing the receive-side checker. Non-IPv4 traffic and option-bearing headers pass through unmodified.

## Interface
- C_S_AXIS_DATA_WIDTH, 256: tdata width; only 256 is supported.
- C_S_AXIS_TUSER_WIDTH, 128: tuser width; passed through unchanged.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- s_axis_tdata / tkeep / tuser  in  256 / 32 / TUSER  input beat; byte n of the beat is tdata[8n+7:8n].
- s_axis_tvalid  in  1; s_axis_tlast  in  1; s_axis_tready  out  1.
- m_axis_tdata / tkeep / tuser  out  256 / 32 / TUSER  output beat.
- m_axis_tvalid  out  1; m_axis_tlast  out  1; m_axis_tready  in  1.
- csum_inserted  out  1  one-cycle pulse when a rewritten first beat transfers on m_axis.

## Operation
- Frame layout, beat 0: bytes 0-13 Ethernet, 12-13 ethertype, 14-31 IP header bytes 0-17, 24-25 checksum field. Beat 1 bytes 0-1 = IP dst low half (frame bytes 32-33).
- Storage: hold register H and output register O, each with a valid bit. Packet-start flag F (set at reset and after each accepted tlast) marks the next accepted beat as beat 0.
- Eligible iff beat 0 has ethertype 0x0800 (byte12 = 0x08, byte13 = 0x00), byte14 = 0x45, tkeep = all ones, tlast = 0. The eligibility bit is latched with beat 0.
- On beat 0 acceptance: register partial sum P (20 bits) = sum of 8 network-order words {byte2i, byte2i+1} for byte pairs 14..31, excluding 24-25. The incoming checksum value is ignored.
- On beat 1 acceptance: S = P + {byte0, byte1}. Fold S1 = S[15:0] + S[19:16], then S2 = S1[15:0] + S1[16]. The checksum is ~S2[15:0].
- If eligible, beat 0 moves H->O with byte24 = csum[15:8] and byte25 = csum[7:0]; all other bytes, tkeep, tuser and tlast are unchanged. If not eligible, beat 0 passes through unchanged.
- Beat 0 in H is held until beat 1 is accepted, unless beat 0 is tlast, in which case it moves freely. All later beats move H->O without waiting.
- Handshake rules:
  - H moves when H valid, (O empty or m_tready), and the hold condition is met.
  - s_axis_tready = !H_valid || H_moves.
  - s_axis_tready may depend on s_axis_tvalid and m_axis_tready; m_axis_tvalid = O_valid, registered.
- csum_inserted asserts on the cycle an eligible beat 0 in O transfers (m_tvalid && m_tready).

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata/tkeep/tuser/tlast 0, csum_inserted 0, s_axis_tready 1 in the cycle after reset deasserts; H, O and eligibility cleared; F = 1.
- Latency:
  - Beat 0 is visible on m_axis the cycle after the edge that accepts beat 1.
  - Beats k≥1 are visible 2 cycles after acceptance when there is no backpressure.
  - Steady-state throughput is 1 beat/cycle.
- Simultaneous events: when H moves and a new beat is accepted on the same edge, H is reloaded; there is no bubble.
- Backpressure: O holds its value while m_tready = 0. H can still fill, then s_tready drops.
- Single-beat packets: ineligible, forwarded unchanged; F stays 1.
- Reset mid-packet: all buffered beats are dropped with no tlast emitted. The first beat accepted after reset is treated as beat 0.
- Bubbles on s_axis between beats 0 and 1: beat 0 waits in H indefinitely; m_tvalid stays 0 if O is empty.

## Test plan
- Checksum insertion: IPv4 header 45 00 00 73 00 00 40 00 40 11 00 00 c0 a8 00 01 c0 a8 00 c7 in a 2-beat frame with ethertype 0800 -> output bytes 24-25 = b8 61, all other bytes identical, one csum_inserted pulse.
- Stale checksum: same frame with checksum field 12 34 -> output b8 61.
- Pass-through cases: ARP frame (ethertype 0806), IPv4 with byte14 = 0x46, and a single-beat IPv4 frame -> all bit-exact pass-through, no csum_inserted pulse.
- Streaming and backpressure: back-to-back 4-beat packets with random m_tready (50%) and random s_tvalid gaps, including a gap between beats 0 and 1 -> no beat loss, duplication or reordering; checksums correct; full throughput when m_tready = 1.
- Carry fold: header of all-0xffff words with version byte 0x45 and ethertype 0800 -> folded result matches a reference model (double-fold exercised), inserted value = ~fold.
- Reset mid-packet: assert reset after beat 0 of an eligible packet -> m_tvalid 0 the next cycle; the following packet is processed correctly from its beat 0.
